sudp_busrx: RTL

- Receive end of the shared 32-bit SU datapath bus, which is driven by tri-state driver banks.
- Samples the bus on cycles where a remote driver asserts its output enable, and queues the captured words in a small show-ahead FIFO for the local consumer.
- Enforces bus-turnaround and contention rules against the local driver enable, and reports violations through sticky error flags.
- Sits beside the local tri-state driver bank on the same bus node.

---
 rtl/sudp_busrx_pkg.sv | 8 +
 rtl/sudp_rxfifo.sv | 57 +++++
 rtl/sudp_busrx.sv | 87 ++++++++
 3 files changed

// File: rtl/sudp_busrx_pkg.sv
// Shared sizing constants for the SU datapath bus receiver.
package sudp_busrx_pkg;

    localparam int unsigned SUDP_WIDTH   = 32;
    localparam int unsigned SUDP_RXDEPTH = 4;
    localparam int unsigned SUDP_RXCNTW  = 3;

endpackage

// File: rtl/sudp_rxfifo.sv
// Show-ahead receive FIFO: storage, pointers, occupancy and full/valid flags.
module sudp_rxfifo
    import sudp_busrx_pkg::*;
#(
    parameter int unsigned WIDTH = SUDP_WIDTH,
    parameter int unsigned DEPTH = SUDP_RXDEPTH,
    parameter int unsigned CNTW  = SUDP_RXCNTW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNTW-1:0]  count,
    output logic             full,
    output logic             vld
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CNTW-1:0]  r_count;

    // Storage write, pointer advance and occupancy tracking; reset clears the array too.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_mem[r_wptr] <= wdata;
                r_wptr        <= r_wptr + PW'(1);
            end
            if (pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rptr];
    assign count = r_count;
    assign vld   = (r_count != '0);
    assign full  = (r_count == CNTW'(DEPTH));

endmodule

// File: rtl/sudp_busrx.sv
// Receive end of the shared SU tri-state bus: capture qualification, turnaround/contention checks, sticky errors.
module sudp_busrx
    import sudp_busrx_pkg::*;
#(
    parameter int unsigned WIDTH = SUDP_WIDTH,
    parameter int unsigned DEPTH = SUDP_RXDEPTH,
    parameter int unsigned CNTW  = SUDP_RXCNTW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] bus_z,
    input  logic             bus_vld,
    input  logic             local_en,
    input  logic             rd_req,
    input  logic             clr_err,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_vld,
    output logic             full,
    output logic [CNTW-1:0]  count,
    output logic             ovf_err,
    output logic             cont_err
);

    logic r_local_en_d;
    logic r_ovf_err;
    logic r_cont_err;

    logic w_cap;
    logic w_cont;
    logic w_turn;
    logic w_pop;
    logic w_push;
    logic w_ovf;
    logic w_full;
    logic w_vld;

    // Remote word is only taken when neither the local bank nor its turnaround cycle owns the bus.
    assign w_cap  = bus_vld & ~local_en & ~r_local_en_d;
    assign w_cont = bus_vld & local_en;
    assign w_turn = bus_vld & ~local_en & r_local_en_d;
    assign w_pop  = rd_req & w_vld;
    assign w_push = w_cap & (~w_full | w_pop);
    assign w_ovf  = w_cap & w_full & ~w_pop;

    // Turnaround tracker and sticky error flags; a new error beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_local_en_d <= 1'b0;
            r_ovf_err    <= 1'b0;
            r_cont_err   <= 1'b0;
        end else begin
            r_local_en_d <= local_en;
            if (w_ovf) begin
                r_ovf_err <= 1'b1;
            end else if (clr_err) begin
                r_ovf_err <= 1'b0;
            end
            if (w_cont | w_turn) begin
                r_cont_err <= 1'b1;
            end else if (clr_err) begin
                r_cont_err <= 1'b0;
            end
        end
    end

    sudp_rxfifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNTW  (CNTW)
    ) u_rxfifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (bus_z),
        .rdata (rd_data),
        .count (count),
        .full  (w_full),
        .vld   (w_vld)
    );

    assign rd_vld   = w_vld;
    assign full     = w_full;
    assign ovf_err  = r_ovf_err;
    assign cont_err = r_cont_err;

endmodule
